// File: rtl/ssc_acia_pkg.sv
// Shared constants for the 6551 ACIA host: register selects, status bit
// positions and the host sequencer states.
package ssc_acia_pkg;

    localparam logic [1:0] RS_DATA    = 2'b00;
    localparam logic [1:0] RS_STATUS  = 2'b01;
    localparam logic [1:0] RS_COMMAND = 2'b10;
    localparam logic [1:0] RS_CONTROL = 2'b11;

    localparam int ST_IRQ  = 7;
    localparam int ST_TDRE = 4;
    localparam int ST_RDRF = 3;
    localparam int ST_OVR  = 2;
    localparam int ST_FE   = 1;
    localparam int ST_PE   = 0;

    // RX FIFO entry: {status[2:0], data byte}
    localparam int RX_W = 11;

    typedef enum logic [2:0] {
        RST_W,
        CMD_W,
        CTL_W,
        POLL,
        RX_R,
        TX_W
    } state_t;

endpackage

// File: rtl/ssc_acia_rx_fifo.sv
// Small RX FIFO holding received bytes together with their error flags.
module ssc_acia_rx_fifo
    import ssc_acia_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk_logic_i,
    input  logic            reset_i,
    input  logic            i_push,
    input  logic [RX_W-1:0] i_wdata,
    input  logic            i_pop,
    output logic [RX_W-1:0] o_rdata,
    output logic            o_full,
    output logic            o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [RX_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    // Empty head reads as zero so the byte outputs rest at 0.
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk_logic_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/ssc_acia_host.sv
// 6551 ACIA bus initiator: programs the chip, polls status, writes TX bytes
// from a valid/ready stream and drains RX bytes into a FIFO.
module ssc_acia_host
    import ssc_acia_pkg::*;
#(
    parameter logic [7:0] CONTROL_INIT = 8'h1E,
    parameter logic [7:0] COMMAND_INIT = 8'h0B,
    parameter int         RX_DEPTH     = 4
) (
    input  logic       clk_logic_i,
    input  logic       reset_i,
    input  logic       phi_stb_i,
    input  logic       enable_i,
    output logic       acia_cs_o,
    output logic       acia_rw_n_o,
    output logic [1:0] acia_rs_o,
    output logic [7:0] acia_wdata_o,
    input  logic [7:0] acia_rdata_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic [2:0] rx_err_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic [7:0] status_o,
    output logic       init_done_o
);

    state_t          r_state;
    logic            r_cs;
    logic            r_rw_n;
    logic [1:0]      r_rs;
    logic [7:0]      r_wdata;
    logic [7:0]      r_tx_data;
    logic            r_tx_ready;
    logic [7:0]      r_status;
    logic            r_init_done;

    logic            w_push;
    logic [RX_W-1:0] w_fifo_rdata;
    logic            w_fifo_full;
    logic            w_fifo_empty;

    // An access completes on the first strobe seen while cs is already high.
    assign w_push = r_cs && phi_stb_i && (r_state == RX_R);

    ssc_acia_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk_logic_i (clk_logic_i),
        .reset_i     (reset_i),
        .i_push      (w_push),
        .i_wdata     ({r_status[ST_OVR:ST_PE], acia_rdata_i}),
        .i_pop       (rx_ready_i),
        .o_rdata     (w_fifo_rdata),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= RST_W;
            r_cs        <= 1'b0;
            r_rw_n      <= 1'b1;
            r_rs        <= 2'b00;
            r_wdata     <= 8'h00;
            r_tx_data   <= 8'h00;
            r_tx_ready  <= 1'b0;
            r_status    <= 8'h00;
            r_init_done <= 1'b0;
        end else begin
            r_tx_ready <= 1'b0;
            if (!r_cs) begin
                if (enable_i) begin
                    r_cs <= 1'b1;
                    case (r_state)
                        RST_W: begin
                            r_rw_n  <= 1'b0;
                            r_rs    <= RS_STATUS;
                            r_wdata <= 8'h00;
                        end
                        CMD_W: begin
                            r_rw_n  <= 1'b0;
                            r_rs    <= RS_COMMAND;
                            r_wdata <= COMMAND_INIT;
                        end
                        CTL_W: begin
                            r_rw_n  <= 1'b0;
                            r_rs    <= RS_CONTROL;
                            r_wdata <= CONTROL_INIT;
                        end
                        RX_R: begin
                            r_rw_n <= 1'b1;
                            r_rs   <= RS_DATA;
                        end
                        TX_W: begin
                            r_rw_n  <= 1'b0;
                            r_rs    <= RS_DATA;
                            r_wdata <= r_tx_data;
                        end
                        default: begin
                            r_rw_n <= 1'b1;
                            r_rs   <= RS_STATUS;
                        end
                    endcase
                end
            end else if (phi_stb_i) begin
                r_cs   <= 1'b0;
                r_rw_n <= 1'b1;
                case (r_state)
                    RST_W: r_state <= CMD_W;
                    CMD_W: r_state <= CTL_W;
                    CTL_W: begin
                        r_state     <= POLL;
                        r_init_done <= 1'b1;
                    end
                    POLL: begin
                        r_status <= acia_rdata_i;
                        // RX wins so the ACIA receiver is drained first.
                        if (acia_rdata_i[ST_RDRF] && !w_fifo_full) begin
                            r_state <= RX_R;
                        end else if (acia_rdata_i[ST_TDRE] && tx_valid_i) begin
                            r_state   <= TX_W;
                            r_tx_data <= tx_data_i;
                        end else begin
                            r_state <= POLL;
                        end
                    end
                    RX_R: r_state <= POLL;
                    TX_W: begin
                        r_state    <= POLL;
                        r_tx_ready <= 1'b1;
                    end
                    default: r_state <= RST_W;
                endcase
            end
        end
    end

    assign acia_cs_o    = r_cs;
    assign acia_rw_n_o  = r_rw_n;
    assign acia_rs_o    = r_rs;
    assign acia_wdata_o = r_wdata;
    assign tx_ready_o   = r_tx_ready;
    assign status_o     = r_status;
    assign init_done_o  = r_init_done;
    assign rx_data_o    = w_fifo_rdata[7:0];
    assign rx_err_o     = w_fifo_rdata[10:8];
    assign rx_valid_o   = !w_fifo_empty;

endmodule

// File: tb/tb_ssc_acia_host.sv
// Bench for ssc_acia_host: a behavioural ACIA plus stream agents drive the
// host; RX and TX byte order and flags are scored against expected queues.
module tb_ssc_acia_host;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       phi_stb = 1'b0;
    logic       cs;
    logic       rw_n;
    logic [1:0] rs;
    logic [7:0] wdata;
    logic [7:0] rdata = 8'h00;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic [2:0] rx_err;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] status;
    logic       init_done;

    always #5 clk = ~clk;

    ssc_acia_host dut (
        .clk_logic_i  (clk),
        .reset_i      (rst),
        .phi_stb_i    (phi_stb),
        .enable_i     (enable),
        .acia_cs_o    (cs),
        .acia_rw_n_o  (rw_n),
        .acia_rs_o    (rs),
        .acia_wdata_o (wdata),
        .acia_rdata_i (rdata),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .rx_data_o    (rx_data),
        .rx_err_o     (rx_err),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rx_ready),
        .status_o     (status),
        .init_done_o  (init_done)
    );

    typedef struct {
        logic       rw_n;
        logic [1:0] rs;
        logic [7:0] wdata;
        logic       init_done;
    } acc_t;

    int          vectors = 0;
    int          miscompares = 0;
    acc_t        log_q[$];
    logic        tdre = 1'b0;
    logic [2:0]  err = 3'b000;
    logic [7:0]  acia_rx_q[$];
    logic [10:0] exp_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  tx_exp_q[$];
    int          tx_pulses = 0;
    int          stb_period = 4;
    int          pop_req = 0;
    bit          auto_pop = 1'b0;
    bit          pop_on_rx = 1'b0;

    function automatic int count_acc(input logic rw, input logic [1:0] r);
        int n = 0;
        foreach (log_q[i]) if (log_q[i].rw_n == rw && log_q[i].rs == r) n++;
        return n;
    endfunction

    function automatic int first_idx(input logic rw, input logic [1:0] r);
        foreach (log_q[i]) if (log_q[i].rw_n == rw && log_q[i].rs == r) return i;
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ACIA model, strobe source, TX source and RX sink, all on the falling edge.
    initial begin : agent
        int          stb_cnt;
        bit          prev_cap;
        bit          prev_wait;
        bit          do_pop;
        acc_t        acc;
        acc_t        prev_acc;
        logic [7:0]  prev_rd;
        logic [7:0]  e8;
        logic [10:0] e11;
        stb_cnt = 0;
        prev_cap = 1'b0;
        prev_wait = 1'b0;
        prev_rd = 8'h00;
        forever begin
            @(negedge clk);
            phi_stb = (stb_cnt == 0);
            stb_cnt = (stb_cnt + 1 >= stb_period) ? 0 : stb_cnt + 1;
            rx_ready = 1'b0;
            if (rst) begin
                tx_valid = 1'b0;
                prev_cap = 1'b0;
                prev_wait = 1'b0;
            end else begin
                if (prev_cap) begin
                    vectors++;
                    if (cs !== 1'b0 || rw_n !== 1'b1) begin
                        miscompares++;
                        $display("FAIL cs_release: cs=%b rw_n=%b, required cs=0 rw_n=1", cs, rw_n);
                    end
                    if (prev_acc.rw_n && prev_acc.rs == 2'b01) begin
                        vectors++;
                        if (status !== prev_rd) begin
                            miscompares++;
                            $display("FAIL status_update: got %h, required %h", status, prev_rd);
                        end
                    end
                    if (!prev_acc.rw_n && prev_acc.rs == 2'b11) begin
                        vectors++;
                        if (init_done !== 1'b1) begin
                            miscompares++;
                            $display("FAIL init_done_rise: got %b, required 1", init_done);
                        end
                    end
                end
                vectors++;
                if (tx_ready !== (prev_cap && !prev_acc.rw_n && prev_acc.rs == 2'b00)) begin
                    miscompares++;
                    $display("FAIL tx_ready_pulse: got %b, required %b", tx_ready,
                             prev_cap && !prev_acc.rw_n && prev_acc.rs == 2'b00);
                end
                if (prev_wait) begin
                    vectors++;
                    if (cs !== 1'b1) begin
                        miscompares++;
                        $display("FAIL cs_hold: cs=%b before strobe, required 1", cs);
                    end
                end
                if (tx_ready === 1'b1) begin
                    tx_pulses++;
                    tx_valid = 1'b0;
                end
                prev_cap = 1'b0;
                prev_wait = 1'b0;
                if (cs === 1'b1 && phi_stb) begin
                    acc.rw_n = rw_n;
                    acc.rs = rs;
                    acc.wdata = wdata;
                    acc.init_done = init_done;
                    log_q.push_back(acc);
                    if (rw_n && rs == 2'b01) begin
                        rdata = {3'b000, tdre, acia_rx_q.size() != 0, err};
                    end else if (rw_n && rs == 2'b00) begin
                        rdata = (acia_rx_q.size() != 0) ? acia_rx_q.pop_front() : 8'h00;
                    end else if (!rw_n && rs == 2'b00) begin
                        vectors++;
                        if (tx_exp_q.size() == 0) begin
                            miscompares++;
                            $display("FAIL tx_write: unexpected data write %h, required none", wdata);
                        end else begin
                            e8 = tx_exp_q.pop_front();
                            if (wdata !== e8) begin
                                miscompares++;
                                $display("FAIL tx_write: wrote %h, required %h", wdata, e8);
                            end
                        end
                    end
                    prev_cap = 1'b1;
                    prev_acc = acc;
                    prev_rd = rdata;
                end else if (cs === 1'b1) begin
                    prev_wait = 1'b1;
                end
                do_pop = (pop_req > 0) || (auto_pop && $urandom_range(0, 1) == 1) ||
                         (pop_on_rx && cs === 1'b1 && phi_stb && rw_n && rs == 2'b00);
                if (do_pop && rx_valid === 1'b1) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL rx_head: got %h, required nothing queued", {rx_err, rx_data});
                    end else begin
                        e11 = exp_q.pop_front();
                        if ({rx_err, rx_data} !== e11) begin
                            miscompares++;
                            $display("FAIL rx_head: got err=%b data=%h, required err=%b data=%h",
                                     rx_err, rx_data, e11[10:8], e11[7:0]);
                        end
                    end
                    rx_ready = 1'b1;
                    if (pop_req > 0) pop_req--;
                end
                if (!tx_valid && tx_q.size() != 0) begin
                    tx_data = tx_q.pop_front();
                    tx_valid = 1'b1;
                    tx_exp_q.push_back(tx_data);
                end
            end
        end
    end

    task automatic test_reset();
        logic [1:0] e_rs[3];
        logic [7:0] e_wd[3];
        int t;
        e_rs = '{2'b01, 2'b10, 2'b11};
        e_wd = '{8'h00, 8'h0B, 8'h1E};
        vectors++;
        if (cs !== 1'b0 || rw_n !== 1'b1 || rs !== 2'b00 || wdata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_bus: cs=%b rw_n=%b rs=%b wdata=%h, required 0 1 00 00", cs, rw_n, rs, wdata);
        end
        vectors++;
        if ({tx_ready, rx_valid, rx_data, rx_err, status, init_done} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: tx_ready=%b rx_valid=%b rx=%h err=%b status=%h init=%b, required all 0",
                     tx_ready, rx_valid, rx_data, rx_err, status, init_done);
        end
        rst = 1'b0;
        enable = 1'b1;
        log_q.delete();
        t = 0;
        while (log_q.size() < 4 && t < 2000) begin tick(1); t++; end
        vectors++;
        if (log_q.size() < 4) begin
            miscompares++;
            $display("FAIL init_timeout: %0d accesses, required 4", log_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (log_q[i].rw_n !== 1'b0 || log_q[i].rs !== e_rs[i] ||
                    log_q[i].wdata !== e_wd[i] || log_q[i].init_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL init_write%0d: rw_n=%b rs=%b data=%h init=%b, required 0 %b %h 0",
                             i, log_q[i].rw_n, log_q[i].rs, log_q[i].wdata, log_q[i].init_done, e_rs[i], e_wd[i]);
                end
            end
            vectors++;
            if (log_q[3].rw_n !== 1'b1 || log_q[3].rs !== 2'b01 || log_q[3].init_done !== 1'b1) begin
                miscompares++;
                $display("FAIL first_poll: rw_n=%b rs=%b init=%b, required 1 01 1",
                         log_q[3].rw_n, log_q[3].rs, log_q[3].init_done);
            end
        end
    endtask

    task automatic test_tx();
        int t;
        int p0;
        int idx;
        tdre = 1'b1;
        log_q.delete();
        p0 = tx_pulses;
        tx_q.push_back(8'h41);
        t = 0;
        while (count_acc(1'b0, 2'b00) < 1 && t < 2000) begin tick(1); t++; end
        tick(40);
        vectors++;
        if (count_acc(1'b0, 2'b00) != 1) begin
            miscompares++;
            $display("FAIL tx_write_count: %0d data writes, required 1", count_acc(1'b0, 2'b00));
        end
        idx = first_idx(1'b0, 2'b00);
        vectors++;
        if (idx < 1 || log_q[(idx < 1) ? 0 : idx - 1].rs !== 2'b01) begin
            miscompares++;
            $display("FAIL tx_after_poll: write index %0d, required a status read before it", idx);
        end
        vectors++;
        if (tx_pulses - p0 != 1) begin
            miscompares++;
            $display("FAIL tx_ready_count: %0d pulses, required 1", tx_pulses - p0);
        end
        vectors++;
        if (status !== 8'h10) begin
            miscompares++;
            $display("FAIL tx_status: got %h, required 10", status);
        end
    endtask

    task automatic test_enable();
        int t;
        int n;
        t = 0;
        while (cs !== 1'b1 && t < 100) begin tick(1); t++; end
        enable = 1'b0;
        n = log_q.size();
        tick(40);
        vectors++;
        if (log_q.size() != n + 1 || cs !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_low: %0d accesses completed, cs=%b, required 1 and cs=0", log_q.size() - n, cs);
        end
        enable = 1'b1;
        tick(40);
        vectors++;
        if (log_q.size() <= n + 1) begin
            miscompares++;
            $display("FAIL enable_resume: %0d accesses, required more than %0d", log_q.size(), n + 1);
        end
    endtask

    task automatic test_rx_priority();
        int t;
        int ri;
        int wi;
        tdre = 1'b0;
        tx_q.push_back(8'($urandom_range(0, 255)));
        tick(30);
        log_q.delete();
        acia_rx_q.push_back(8'h5A);
        exp_q.push_back({3'b000, 8'h5A});
        tdre = 1'b1;
        t = 0;
        while (count_acc(1'b0, 2'b00) < 1 && t < 2000) begin tick(1); t++; end
        ri = first_idx(1'b1, 2'b00);
        wi = first_idx(1'b0, 2'b00);
        vectors++;
        if (ri < 0 || wi < 0 || ri > wi) begin
            miscompares++;
            $display("FAIL rx_priority: rx read at %0d, tx write at %0d, required read first", ri, wi);
        end
        vectors++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h5A || rx_err !== 3'b000) begin
            miscompares++;
            $display("FAIL rx_byte: valid=%b data=%h err=%b, required 1 5a 000", rx_valid, rx_data, rx_err);
        end
        pop_req = 1;
        t = 0;
        while (pop_req != 0 && t < 100) begin tick(1); t++; end
    endtask

    task automatic test_fifo_full();
        int t;
        logic [7:0] b;
        tdre = 1'b0;
        log_q.delete();
        for (int i = 0; i < 5; i++) begin
            b = (i == 4) ? 8'hA5 : 8'($urandom_range(0, 255));
            acia_rx_q.push_back(b);
            exp_q.push_back({3'b000, b});
        end
        t = 0;
        while (count_acc(1'b1, 2'b00) < 4 && t < 2000) begin tick(1); t++; end
        tick(60);
        vectors++;
        if (count_acc(1'b1, 2'b00) != 4 || acia_rx_q.size() != 1) begin
            miscompares++;
            $display("FAIL fifo_full_hold: %0d data reads, %0d left in ACIA, required 4 and 1",
                     count_acc(1'b1, 2'b00), acia_rx_q.size());
        end
        vectors++;
        if (count_acc(1'b1, 2'b01) < 8) begin
            miscompares++;
            $display("FAIL fifo_full_polls: %0d status reads, required at least 8", count_acc(1'b1, 2'b01));
        end
        pop_req = 1;
        t = 0;
        while (count_acc(1'b1, 2'b00) < 5 && t < 2000) begin tick(1); t++; end
        vectors++;
        if (count_acc(1'b1, 2'b00) != 5 || acia_rx_q.size() != 0) begin
            miscompares++;
            $display("FAIL fifo_refill: %0d data reads, required 5", count_acc(1'b1, 2'b00));
        end
        tick(2);
        pop_req = 4;
        t = 0;
        while (pop_req != 0 && t < 200) begin tick(1); t++; end
        tick(2);
        vectors++;
        if (pop_req != 0 || rx_valid !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL fifo_drain: pending pops %0d, rx_valid=%b, %0d expected left, required 0 0 0",
                     pop_req, rx_valid, exp_q.size());
        end
    endtask

    task automatic test_err_simul();
        int t;
        logic [7:0] b[2];
        tdre = 1'b0;
        err = 3'b000;
        log_q.delete();
        for (int i = 0; i < 2; i++) begin
            b[i] = 8'($urandom_range(0, 255));
            acia_rx_q.push_back(b[i]);
            exp_q.push_back({3'b000, b[i]});
        end
        t = 0;
        while (count_acc(1'b1, 2'b00) < 2 && t < 2000) begin tick(1); t++; end
        tick(10);
        err = 3'b101;
        acia_rx_q.push_back(8'h33);
        exp_q.push_back({3'b101, 8'h33});
        pop_on_rx = 1'b1;
        t = 0;
        while (count_acc(1'b1, 2'b00) < 3 && t < 2000) begin tick(1); t++; end
        pop_on_rx = 1'b0;
        tick(1);
        vectors++;
        if (exp_q.size() != 2 || rx_valid !== 1'b1 || rx_data !== b[1]) begin
            miscompares++;
            $display("FAIL push_pop_same: %0d queued, valid=%b head=%h, required 2 1 %h",
                     exp_q.size(), rx_valid, rx_data, b[1]);
        end
        pop_req = 1;
        tick(3);
        vectors++;
        if (rx_data !== 8'h33 || rx_err !== 3'b101) begin
            miscompares++;
            $display("FAIL rx_err_flags: data=%h err=%b, required 33 101", rx_data, rx_err);
        end
        pop_req = 1;
        tick(3);
        vectors++;
        if (rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL push_pop_count: rx_valid=%b after two pops, required 0", rx_valid);
        end
        err = 3'b000;
    endtask

    task automatic test_back_to_back();
        int t;
        logic [7:0] b;
        for (int round = 0; round < 3; round++) begin
            stb_period = $urandom_range(1, 6);
            tdre = 1'b1;
            auto_pop = 1'b1;
            for (int i = 0; i < 5; i++) tx_q.push_back(8'($urandom_range(0, 255)));
            for (int i = 0; i < 5; i++) begin
                t = 0;
                while (acia_rx_q.size() != 0 && t < 2000) begin tick(1); t++; end
                tick($urandom_range(0, 20));
                b = 8'($urandom_range(0, 255));
                err = 3'($urandom_range(0, 7));
                acia_rx_q.push_back(b);
                exp_q.push_back({err, b});
            end
            t = 0;
            while ((tx_q.size() != 0 || tx_exp_q.size() != 0 || tx_valid || acia_rx_q.size() != 0 ||
                    exp_q.size() != 0) && t < 5000) begin
                tick(1);
                t++;
            end
            vectors++;
            if (tx_exp_q.size() != 0 || tx_valid || exp_q.size() != 0 || acia_rx_q.size() != 0) begin
                miscompares++;
                $display("FAIL stream_round%0d: tx left %0d, rx left %0d, acia rx %0d, required all 0",
                         round, tx_exp_q.size() + tx_q.size(), exp_q.size(), acia_rx_q.size());
            end
            auto_pop = 1'b0;
            err = 3'b000;
        end
        stb_period = 4;
        tdre = 1'b0;
        tick(10);
    endtask

    task automatic test_reset_mid_tx();
        int t;
        int p0;
        logic [1:0] e_rs[3];
        logic [7:0] e_wd[3];
        e_rs = '{2'b01, 2'b10, 2'b11};
        e_wd = '{8'h00, 8'h0B, 8'h1E};
        tdre = 1'b0;
        log_q.delete();
        acia_rx_q.push_back(8'($urandom_range(0, 255)));
        exp_q.push_back({3'b000, acia_rx_q[0]});
        t = 0;
        while (count_acc(1'b1, 2'b00) < 1 && t < 2000) begin tick(1); t++; end
        tx_q.push_back(8'($urandom_range(0, 255)));
        tdre = 1'b1;
        t = 0;
        while (!(cs === 1'b1 && rw_n === 1'b0 && rs === 2'b00) && t < 2000) begin tick(1); t++; end
        vectors++;
        if (!(cs === 1'b1 && rw_n === 1'b0 && rs === 2'b00)) begin
            miscompares++;
            $display("FAIL reset_mid_tx_setup: cs=%b rw_n=%b rs=%b, required a data write in flight", cs, rw_n, rs);
        end
        p0 = tx_pulses;
        rst = 1'b1;
        #1;
        vectors++;
        if (cs !== 1'b0 || rw_n !== 1'b1 || rx_valid !== 1'b0 || init_done !== 1'b0 || status !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_async: cs=%b rw_n=%b rx_valid=%b init=%b status=%h, required 0 1 0 0 00",
                     cs, rw_n, rx_valid, init_done, status);
        end
        tx_q.delete();
        tx_exp_q.delete();
        exp_q.delete();
        tdre = 1'b0;
        tick(3);
        rst = 1'b0;
        log_q.delete();
        t = 0;
        while (log_q.size() < 3 && t < 2000) begin tick(1); t++; end
        vectors++;
        if (log_q.size() < 3) begin
            miscompares++;
            $display("FAIL reinit_timeout: %0d accesses, required 3", log_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (log_q[i].rw_n !== 1'b0 || log_q[i].rs !== e_rs[i] || log_q[i].wdata !== e_wd[i]) begin
                    miscompares++;
                    $display("FAIL reinit_write%0d: rw_n=%b rs=%b data=%h, required 0 %b %h",
                             i, log_q[i].rw_n, log_q[i].rs, log_q[i].wdata, e_rs[i], e_wd[i]);
                end
            end
        end
        tick(10);
        vectors++;
        if (tx_pulses != p0) begin
            miscompares++;
            $display("FAIL reset_no_tx_ready: %0d pulses, required 0", tx_pulses - p0);
        end
    endtask

    initial begin
        tick(3);
        test_reset();
        test_tx();
        test_enable();
        test_rx_priority();
        test_fifo_full();
        test_err_simul();
        test_back_to_back();
        test_reset_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
